// File: rtl/conv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared types and sizing helpers for the output-stationary convolution
// tile controller and its loop counter.
//   state_t          : controller FSM states
//   ofm_size()       : output feature-map side for a given input/kernel/stride
//   num_tile()       : number of S-row tiles covering the whole OFM plane
//   compute_cycles() : cycles needed to drain one buffer load through the
//                      skewed array (load beats plus diagonal fill/drain)
//   idx_width()      : bit width able to hold 0..max_val
// ---------------------------------------------------------------------------
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        WRITE,
        CLEAR,
        FINISH
    } state_t;

    function automatic int ofm_size(input int ifm, input int k, input int stride);
        return (ifm - k) / stride + 1;
    endfunction

    function automatic int num_tile(input int ofm, input int s);
        return (ofm * ofm + s - 1) / s;
    endfunction

    function automatic int compute_cycles(input int buffer_size, input int s);
        return buffer_size + 2 * s - 1;
    endfunction

    function automatic int idx_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// ---------------------------------------------------------------------------
// conv_loop_counter
// Nested loop indices for one layer: filter group (outer), OFM tile, input
// channel (inner). Indices wrap back to zero after the last tile of the last
// group, so the layer always ends with every index at zero.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : force all indices to zero
//   inc_chan          : advance to the next input channel of the same tile
//   inc_tile          : tile finished; restart channels, advance tile/group
//   group_idx/tile_idx/chan_idx : current indices
//   last_chan/last_tile/last_group : index currently at its final value
// ---------------------------------------------------------------------------
module conv_loop_counter #(
    parameter int NUM_GROUP = 1,
    parameter int NUM_TILE  = 1,
    parameter int NUM_CHAN  = 1,
    parameter int GROUP_W   = 1,
    parameter int TILE_W    = 1,
    parameter int CHAN_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc_chan,
    input  logic               inc_tile,
    output logic [GROUP_W-1:0] group_idx,
    output logic [TILE_W-1:0]  tile_idx,
    output logic [CHAN_W-1:0]  chan_idx,
    output logic               last_chan,
    output logic               last_tile,
    output logic               last_group
);

    assign last_chan  = (chan_idx  == CHAN_W'(NUM_CHAN - 1));
    assign last_tile  = (tile_idx  == TILE_W'(NUM_TILE - 1));
    assign last_group = (group_idx == GROUP_W'(NUM_GROUP - 1));

    // Finishing a tile always restarts the channel loop; the tile index wraps
    // into the next group, and the group index wraps to zero after the final
    // group so the indices read zero once the layer is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            group_idx <= '0;
            tile_idx  <= '0;
            chan_idx  <= '0;
        end else if (clear) begin
            group_idx <= '0;
            tile_idx  <= '0;
            chan_idx  <= '0;
        end else if (inc_tile) begin
            chan_idx <= '0;
            if (last_tile) begin
                tile_idx  <= '0;
                group_idx <= last_group ? '0 : group_idx + GROUP_W'(1);
            end else begin
                tile_idx <= tile_idx + TILE_W'(1);
            end
        end else if (inc_chan) begin
            chan_idx <= chan_idx + CHAN_W'(1);
        end
    end

endmodule

// File: rtl/conv_tile_controller.sv
// ---------------------------------------------------------------------------
// conv_tile_controller
// Sequencer for the output-stationary systolic convolution array. For every
// filter group and OFM tile it loads and computes each input channel in turn
// (partial sums stay in the PEs), shifts the S result rows out, then clears
// the PEs for the next tile.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   start                          : launch one layer (only honoured in IDLE)
//   data_valid                     : IFM/weight buffers hold a valid beat
//   ofm_ready                      : OFM sink accepts a row
//   ifm_read_en, weight_read_en    : buffer pops
//   ifm_in_valid, weight_in_valid  : per-lane skewed valid masks
//   set_reg_compute                : per-diagonal PE accumulate enables
//   set_reg_write                  : PE result-chain shift enables
//   ofm_in_valid, ofm_write_en     : result row valid / OFM write
//   sel_mux                        : PE output mux, 1 selects shift-out path
//   pe_clear                       : PE accumulator clear
//   group_idx, tile_idx, chan_idx  : current loop indices
//   busy, done                     : layer in progress / completion pulse
// ---------------------------------------------------------------------------
module conv_tile_controller
    import conv_ctrl_pkg::*;
#(
    parameter int SYSTOLIC_SIZE  = 16,
    parameter int WEIGHT_SIZE    = 3,
    parameter int IFM_SIZE       = 64,
    parameter int IFM_CHANNEL    = 3,
    parameter int WEIGHT_FILTER  = 16,
    parameter int STRIDE         = 1,
    localparam int BUFFER_SIZE    = WEIGHT_SIZE * WEIGHT_SIZE,
    localparam int OFM_SIZE       = ofm_size(IFM_SIZE, WEIGHT_SIZE, STRIDE),
    localparam int NUM_TILE       = num_tile(OFM_SIZE, SYSTOLIC_SIZE),
    localparam int NUM_GROUP      = WEIGHT_FILTER / SYSTOLIC_SIZE,
    localparam int COMPUTE_CYCLES = compute_cycles(BUFFER_SIZE, SYSTOLIC_SIZE),
    localparam int GROUP_W        = idx_width(NUM_GROUP),
    localparam int TILE_W         = idx_width(NUM_TILE),
    localparam int CHAN_W         = idx_width(IFM_CHANNEL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       data_valid,
    input  logic                       ofm_ready,
    output logic                       ifm_read_en,
    output logic                       weight_read_en,
    output logic [SYSTOLIC_SIZE-1:0]   ifm_in_valid,
    output logic [SYSTOLIC_SIZE-1:0]   weight_in_valid,
    output logic [2*SYSTOLIC_SIZE-2:0] set_reg_compute,
    output logic [SYSTOLIC_SIZE-2:0]   set_reg_write,
    output logic                       ofm_in_valid,
    output logic                       ofm_write_en,
    output logic                       sel_mux,
    output logic                       pe_clear,
    output logic [GROUP_W-1:0]         group_idx,
    output logic [TILE_W-1:0]          tile_idx,
    output logic [CHAN_W-1:0]          chan_idx,
    output logic                       busy,
    output logic                       done
);

    // One step counter serves LOAD beats, COMPUTE cycles and WRITE rows;
    // COMPUTE_CYCLES is the largest of the three limits.
    localparam int STEP_W = idx_width(COMPUTE_CYCLES);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                inc_chan, inc_tile, clear_idx;
    logic                last_chan, last_tile, last_group;

    logic [SYSTOLIC_SIZE-1:0]   lane_mask_d, lane_mask_q;
    logic [2*SYSTOLIC_SIZE-2:0] diag_mask_d, diag_mask_q;
    logic [SYSTOLIC_SIZE-2:0]   wr_mask_d, wr_mask_q;
    logic                       load_q, write_q;
    logic                       pe_clear_q, busy_q, done_q;

    conv_loop_counter #(
        .NUM_GROUP (NUM_GROUP),
        .NUM_TILE  (NUM_TILE),
        .NUM_CHAN  (IFM_CHANNEL),
        .GROUP_W   (GROUP_W),
        .TILE_W    (TILE_W),
        .CHAN_W    (CHAN_W)
    ) u_loop (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_idx),
        .inc_chan   (inc_chan),
        .inc_tile   (inc_tile),
        .group_idx  (group_idx),
        .tile_idx   (tile_idx),
        .chan_idx   (chan_idx),
        .last_chan  (last_chan),
        .last_tile  (last_tile),
        .last_group (last_group)
    );

    // State and step counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic. LOAD only counts beats the buffers actually deliver
    // and WRITE only counts rows the sink accepts, so stalls simply stretch
    // those phases. Channels loop back to LOAD without clearing the PEs.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        inc_chan  = 1'b0;
        inc_tile  = 1'b0;
        clear_idx = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    step_d  = '0;
                end
            end
            LOAD: begin
                if (data_valid) begin
                    if (step_q == STEP_W'(BUFFER_SIZE - 1)) begin
                        state_d = COMPUTE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (step_q == STEP_W'(COMPUTE_CYCLES - 1)) begin
                    step_d = '0;
                    if (last_chan) begin
                        state_d = WRITE;
                    end else begin
                        state_d  = LOAD;
                        inc_chan = 1'b1;
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            WRITE: begin
                if (ofm_ready) begin
                    if (step_q == STEP_W'(SYSTOLIC_SIZE - 1)) begin
                        state_d = CLEAR;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            CLEAR: begin
                inc_tile = 1'b1;
                state_d  = (last_tile && last_group) ? FINISH : LOAD;
            end
            FINISH: begin
                clear_idx = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Skew masks for the upcoming cycle. Lane i sees BUFFER_SIZE beats
    // starting at step i; diagonal j accumulates one cycle behind the lane
    // data reaching it. During WRITE the shift chain narrows by one stage per
    // row already emitted.
    always_comb begin
        lane_mask_d = '0;
        diag_mask_d = '0;
        wr_mask_d   = '0;
        case (state_d)
            LOAD: begin
                lane_mask_d = '1;
            end
            COMPUTE: begin
                for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                    lane_mask_d[i] = (int'(step_d) >= i) &&
                                     (int'(step_d) < i + BUFFER_SIZE);
                end
                for (int j = 0; j < 2 * SYSTOLIC_SIZE - 1; j++) begin
                    diag_mask_d[j] = (int'(step_d) >= j + 1) &&
                                     (int'(step_d) <= j + BUFFER_SIZE);
                end
            end
            WRITE: begin
                for (int i = 0; i < SYSTOLIC_SIZE - 1; i++) begin
                    wr_mask_d[i] = (int'(step_d) <= i);
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers decoded from the next state, so each output lines up
    // with the cycle in which the state register holds that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_mask_q <= '0;
            diag_mask_q <= '0;
            wr_mask_q   <= '0;
            load_q      <= 1'b0;
            write_q     <= 1'b0;
            pe_clear_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lane_mask_q <= lane_mask_d;
            diag_mask_q <= diag_mask_d;
            wr_mask_q   <= wr_mask_d;
            load_q      <= (state_d == LOAD);
            write_q     <= (state_d == WRITE);
            pe_clear_q  <= (state_d == IDLE) || (state_d == CLEAR) ||
                           (state_d == FINISH);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == FINISH);
        end
    end

    // Pops and row writes are gated by the live handshake inputs so a stalled
    // cycle never consumes a beat or emits a row.
    assign ifm_read_en     = load_q & data_valid;
    assign weight_read_en  = load_q & data_valid;
    assign ifm_in_valid    = lane_mask_q;
    assign weight_in_valid = lane_mask_q;
    assign set_reg_compute = diag_mask_q;
    assign set_reg_write   = wr_mask_q & {(SYSTOLIC_SIZE-1){ofm_ready}};
    assign ofm_in_valid    = write_q & ofm_ready;
    assign ofm_write_en    = write_q & ofm_ready;
    assign sel_mux         = write_q & ofm_ready;
    assign pe_clear        = pe_clear_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_conv_tile_controller.sv
// ---------------------------------------------------------------------------
// tb_conv_tile_controller
// Directed bench for the tile controller with S=4, K=3, IFM=6, C=2, F=8,
// STRIDE=1 (OFM=4, 4 tiles, 2 groups, 16 compute cycles, 441-cycle layer).
// Cycle numbers below count from 1 = first cycle after start is taken.
// ---------------------------------------------------------------------------
module tb_conv_tile_controller;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       data_valid;
    logic       ofm_ready;
    logic       ifm_read_en;
    logic       weight_read_en;
    logic [3:0] ifm_in_valid;
    logic [3:0] weight_in_valid;
    logic [6:0] set_reg_compute;
    logic [2:0] set_reg_write;
    logic       ofm_in_valid;
    logic       ofm_write_en;
    logic       sel_mux;
    logic       pe_clear;
    logic [1:0] group_idx;
    logic [2:0] tile_idx;
    logic [1:0] chan_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;
    int cyc, reads, writes, dones, doneCyc, loadBursts, writeBursts;
    logic prevRead, prevWrite;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    conv_tile_controller #(
        .SYSTOLIC_SIZE (S),
        .WEIGHT_SIZE   (3),
        .IFM_SIZE      (6),
        .IFM_CHANNEL   (2),
        .WEIGHT_FILTER (8),
        .STRIDE        (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .data_valid      (data_valid),
        .ofm_ready       (ofm_ready),
        .ifm_read_en     (ifm_read_en),
        .weight_read_en  (weight_read_en),
        .ifm_in_valid    (ifm_in_valid),
        .weight_in_valid (weight_in_valid),
        .set_reg_compute (set_reg_compute),
        .set_reg_write   (set_reg_write),
        .ofm_in_valid    (ofm_in_valid),
        .ofm_write_en    (ofm_write_en),
        .sel_mux         (sel_mux),
        .pe_clear        (pe_clear),
        .group_idx       (group_idx),
        .tile_idx        (tile_idx),
        .chan_idx        (chan_idx),
        .busy            (busy),
        .done            (done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drives one cycle of inputs just after the rising edge, then samples on
    // the falling edge and accumulates burst/pulse statistics.
    task automatic applyStimulus(input logic dv, input logic rdy, input logic st);
        @(posedge clk);
        #1;
        data_valid = dv;
        ofm_ready  = rdy;
        start      = st;
        cyc++;
        @(negedge clk);
        if (ifm_read_en) reads++;
        if (ifm_read_en && !prevRead) loadBursts++;
        prevRead = ifm_read_en;
        if (ofm_write_en) writes++;
        if (ofm_write_en && !prevWrite) writeBursts++;
        prevWrite = ofm_write_en;
        if (done) begin
            dones++;
            doneCyc = cyc;
        end
    endtask

    // Everything except pe_clear must be low while idle or in reset.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_outs"}, 32'({ifm_read_en, weight_read_en, ifm_in_valid,
                    weight_in_valid, set_reg_compute, set_reg_write, ofm_in_valid,
                    ofm_write_en, sel_mux, busy, done, group_idx, tile_idx,
                    chan_idx}), 0);
        checkOutput({tag, "_peclr"}, 32'(pe_clear), 1);
    endtask

    // Per-cycle expectations, keyed on mode (0 plain, 1 load stall,
    // 2 write backpressure) and cycle number.
    task automatic checkCycle(input int mode);
        if (mode != 1 && cyc == 1) begin
            checkOutput("c1_idx", 32'({group_idx, tile_idx, chan_idx}), 0);
            checkOutput("c1_busy", 32'(busy), 1);
            checkOutput("c1_lanes", 32'(ifm_in_valid), 'hF);
        end
        if (mode == 0) begin
            if (cyc == 13) begin
                checkOutput("n3_ifm", 32'(ifm_in_valid), 'hF);
                checkOutput("n3_wgt", 32'(weight_in_valid), 'hF);
                checkOutput("n3_diag", 32'(set_reg_compute), 'h07);
            end
            if (cyc == 21) checkOutput("n11_ifm", 32'(ifm_in_valid), 'h8);
            if (cyc == 22) begin
                checkOutput("n12_ifm", 32'(ifm_in_valid), 'h0);
                checkOutput("n12_diag", 32'(set_reg_compute), 'h78);
            end
            if (cyc == 25) checkOutput("acc_clr25", 32'({pe_clear, chan_idx}), 0);
            if (cyc == 26) begin
                checkOutput("acc_clr26", 32'(pe_clear), 0);
                checkOutput("acc_chan26", 32'(chan_idx), 1);
                checkOutput("acc_rd26", 32'(ifm_read_en), 1);
            end
            if (cyc == 51) begin
                checkOutput("wr51_chan", 32'(chan_idx), 1);
                checkOutput("wr51_ctl", 32'({ofm_in_valid, ofm_write_en, sel_mux}), 'h7);
                checkOutput("wr51_srw", 32'(set_reg_write), 'h7);
            end
            if (cyc == 54) checkOutput("wr54", 32'({ofm_write_en, set_reg_write}), 'h8);
            if (cyc == 55) checkOutput("clr55", 32'({pe_clear, ofm_write_en}), 'h2);
            if (cyc == 56) checkOutput("t1_idx", 32'({group_idx, tile_idx, chan_idx}), 'h04);
            if (cyc == 221) checkOutput("g1_idx", 32'({group_idx, tile_idx, chan_idx}), 'h20);
            if (cyc == 441) begin
                checkOutput("fin_done", 32'({done, pe_clear}), 'h3);
                checkOutput("fin_idx", 32'({group_idx, tile_idx, chan_idx}), 0);
            end
        end
        if (mode == 1) begin
            if (cyc == 2) checkOutput("st2", 32'({ifm_read_en, weight_read_en, ifm_in_valid}), 'hF);
            if (cyc == 17) checkOutput("st17_rd", 32'(ifm_read_en), 1);
            if (cyc == 18) begin
                checkOutput("st18_rd", 32'(ifm_read_en), 0);
                checkOutput("st18_ifm", 32'(ifm_in_valid), 'h1);
                checkOutput("st18_diag", 32'(set_reg_compute), 0);
            end
        end
        if (mode == 2) begin
            if (cyc == 52) checkOutput("bp52", 32'({ofm_write_en, set_reg_write}), 'hE);
            if (cyc == 53) checkOutput("bp53", 32'({ofm_write_en, sel_mux, set_reg_write}), 0);
            if (cyc == 57) checkOutput("bp57", 32'({ofm_write_en, ofm_in_valid, set_reg_write}), 0);
            if (cyc == 58) checkOutput("bp58", 32'({ofm_write_en, set_reg_write}), 'hC);
            if (cyc == 59) checkOutput("bp59", 32'({ofm_write_en, set_reg_write}), 'h8);
            if (cyc == 60) checkOutput("bp60", 32'({pe_clear, ofm_write_en}), 'h2);
        end
    endtask

    // Starts a layer and runs it until done, the cycle budget, or abortAt.
    task automatic runLayer(input int mode, input int abortAt);
        int nxt;
        logic dv, rdy, st;
        applyStimulus(1'b0, 1'b1, 1'b1);
        cyc = 0; reads = 0; writes = 0; dones = 0; doneCyc = 0;
        loadBursts = 0; writeBursts = 0; prevRead = 1'b0; prevWrite = 1'b0;
        while (dones == 0 && cyc < 1000 && !(abortAt > 0 && cyc >= abortAt)) begin
            nxt = cyc + 1;
            dv  = 1'b1;
            rdy = 1'b1;
            st  = 1'b0;
            if (mode == 1 && nxt <= 17) dv = (nxt % 2 == 1);
            if (mode == 2 && nxt >= 53 && nxt <= 57) rdy = 1'b0;
            if (mode == 0 && (nxt == 100 || nxt == 441)) st = 1'b1;
            applyStimulus(dv, rdy, st);
            checkCycle(mode);
        end
        if (abortAt == 0) checkOutput("done_seen", 32'(dones), 1);
    endtask

    // Whole-layer totals for an unstalled run, plus the start-in-FINISH check.
    task automatic checkLayerTotals(input string tag);
        checkOutput({tag, "_reads"}, reads, 144);
        checkOutput({tag, "_ldburst"}, loadBursts, 16);
        checkOutput({tag, "_writes"}, writes, 32);
        checkOutput({tag, "_wrburst"}, writeBursts, 8);
        checkOutput({tag, "_donecyc"}, doneCyc, 441);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_idle1"}, 32'({busy, done}), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_idle2"}, 32'({busy, ifm_read_en}), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_valid = 1'b0; ofm_ready = 1'b0;
        cyc = 0; prevRead = 1'b0; prevWrite = 1'b0;
        @(negedge clk);
        checkIdleOutputs("por");
        @(posedge clk);
        #1 rst = 1'b0;

        runLayer(0, 0);
        checkLayerTotals("base");

        runLayer(1, 20);
        checkOutput("stall_reads", reads, 9);

        // Asynchronous reset in the middle of COMPUTE, held two cycles.
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("rstA");
        @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("rstB");
        @(posedge clk);
        #1 rst = 1'b0;

        runLayer(0, 0);
        checkLayerTotals("after_rst");

        runLayer(2, 0);
        checkOutput("bp_writes", writes, 32);
        checkOutput("bp_donecyc", doneCyc, 446);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
